// File: rtl/fifo_pkt_reader.sv
// Read-side consumer for the synchronous FIFO: credit-limited reads feed a 3-entry
// skid buffer, and the stream is framed into PKT_LEN-word packets plus an XOR checksum beat.
module fifo_pkt_reader #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [15:0]       pkt_count
);
  localparam int         DEPTH     = 3;
  localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

  typedef enum logic {S_DATA, S_CSUM} state_e;

  state_e                       state_q, state_d;
  logic [DEPTH-1:0][DATA_W-1:0] buf_q;
  logic [1:0]                   head_q, head_d;
  logic [1:0]                   occ_q, occ_d;
  logic                         inflight_q;
  logic [7:0]                   beat_q, beat_d;
  logic [DATA_W-1:0]            csum_q, csum_d;
  logic [15:0]                  pkt_q, pkt_d;
  logic                         push, pop;
  logic [2:0]                   credit_used, tail_sum;
  logic [1:0]                   tail;

  // Occupancy plus the word still in flight bounds outstanding reads to the buffer depth,
  // so a capture always finds a free slot and m_ready never reaches fifo_r_en.
  assign credit_used = {1'b0, occ_q} + {2'b0, inflight_q};
  assign fifo_r_en   = !rst && !fifo_empty && (credit_used < 3'(DEPTH));
  assign push        = inflight_q;

  assign tail_sum = {1'b0, head_q} + {1'b0, occ_q};
  assign tail     = (tail_sum >= 3'(DEPTH)) ? 2'(tail_sum - 3'(DEPTH)) : tail_sum[1:0];

  always_ff @(posedge clk) begin
    if (rst)       buf_q       <= '0;
    else if (push) buf_q[tail] <= fifo_rdata;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    beat_d  = beat_q;
    csum_d  = csum_q;
    pkt_d   = pkt_q;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_DATA: begin
        m_valid = (occ_q != 2'd0);
        if (m_valid) m_data = buf_q[head_q];
        if (m_valid && m_ready) begin
          pop    = 1'b1;
          csum_d = csum_q ^ buf_q[head_q];
          beat_d = beat_q + 8'd1;
          if (beat_q == LAST_BEAT) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        // Buffer keeps filling here; only the pop is suppressed.
        m_valid = 1'b1;
        m_data  = csum_q;
        m_last  = 1'b1;
        if (m_ready) begin
          csum_d  = '0;
          beat_d  = '0;
          pkt_d   = pkt_q + 16'd1;
          state_d = S_DATA;
        end
      end
      default: state_d = S_DATA;
    endcase
    if (pop) head_d = (head_q == 2'(DEPTH - 1)) ? 2'd0 : head_q + 2'd1;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_DATA;
      head_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      csum_q     <= '0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_r_en;
      beat_q     <= beat_d;
      csum_q     <= csum_d;
      pkt_q      <= pkt_d;
    end
  end

  assign pkt_count = pkt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: queue-based FIFO and packet model, directed phases then random traffic.
module tb_fifo_pkt_reader;
  localparam int DW = 8;
  localparam int PL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fifo_empty, fifo_r_en, m_valid, m_ready, m_last;
  logic [DW-1:0] fifo_rdata = '0;
  logic [DW-1:0] m_data;
  logic [15:0]   pkt_count;

  logic          fifo_empty1, fifo_r_en1, m_valid1, m_last1;
  logic [DW-1:0] fifo_rdata1 = '0;
  logic [DW-1:0] m_data1;
  logic [15:0]   pkt_count1;

  fifo_pkt_reader #(.DATA_W(DW), .PKT_LEN(PL)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .pkt_count(pkt_count));

  fifo_pkt_reader #(.DATA_W(DW), .PKT_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_rdata(fifo_rdata1),
    .fifo_r_en(fifo_r_en1), .m_valid(m_valid1), .m_ready(1'b1), .m_data(m_data1),
    .m_last(m_last1), .pkt_count(pkt_count1));

  // Behavioural FIFO: writes from the stimulus, reads with one-cycle latency.
  logic [DW-1:0] fmem [0:1023];
  int   wr_ptr = 0, rd_ptr = 0, wr1 = 0, rd1 = 0;
  logic flush = 1'b0;
  assign fifo_empty  = (rd_ptr == wr_ptr);
  assign fifo_empty1 = (rd1 == wr1);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_r_en) begin
      fifo_rdata <= fmem[rd_ptr[9:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    if (fifo_r_en1) begin
      fifo_rdata1 <= 8'h5A;
      rd1         <= rd1 + 1;
    end
  end

  int vecs = 0, miscmp = 0, cyc = 0;
  int mcnt = 0, mpkts = 0, issued = 0, popped = 0, ren_total = 0;
  int first_ren = -1, first_vld = -1, vrun = 0, maxrun = 0, base, pad;
  logic [DW-1:0] mcsum = '0, last_cs = '0, prev_data = '0;
  bit   hold_prev = 0, prev_last = 0, rst_prev = 0, started = 0, push1 = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cs_log[$];
  logic [8:0]    q1[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, then check the settled outputs against the model.
  task automatic tick(input logic rdy, input logic r, input logic fl, input bit dop,
                      input logic [DW-1:0] pd);
    bit hs, exp_ren;
    @(negedge clk);
    m_ready = rdy;
    rst     = r;
    flush   = fl;
    if (dop) begin
      fmem[wr_ptr[9:0]] = pd;
      wr_ptr++;
      exp_q.push_back(pd);
    end
    if (push1) begin
      wr1++;
      push1 = 0;
    end
    #1;
    cyc++;
    if (started) begin
      exp_ren = !r && !fifo_empty && ((issued - popped) < 3);
      chk("r_en", fifo_r_en, exp_ren);
      if (rst_prev) begin
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
      end else begin
        if (hold_prev) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, prev_data);
          chk("hold_last", m_last, prev_last);
        end
        if (mcnt == PL && !r) chk("csum_valid", m_valid, 1);
      end
      chk("pkt_count", pkt_count, 16'(mpkts));
      if (m_valid !== 1'b1) begin
        chk("idle_data", m_data, 0);
        chk("idle_last", m_last, 0);
      end
      hs = (m_valid === 1'b1) && rdy && !r;
      if (hs) begin
        if (mcnt < PL) begin
          if (exp_q.size() == 0) chk("beat_unexp", m_valid, 0);
          else begin
            chk("beat_data", m_data, exp_q[0]);
            chk("beat_last", m_last, 0);
            mcsum = mcsum ^ exp_q[0];
            void'(exp_q.pop_front());
            mcnt++;
            popped++;
          end
        end else begin
          chk("csum_data", m_data, mcsum);
          chk("csum_last", m_last, 1);
          last_cs = m_data;
          cs_log.push_back(m_data);
          mcnt  = 0;
          mcsum = '0;
          mpkts++;
        end
      end
      if (fifo_r_en === 1'b1 && !r) begin
        issued++;
        ren_total++;
        if (first_ren < 0) first_ren = cyc;
      end
      if (m_valid === 1'b1 && first_vld < 0) first_vld = cyc;
      chk("credit", (issued - popped) <= 3, 1);
      vrun   = (m_valid === 1'b1) ? vrun + 1 : 0;
      maxrun = (vrun > maxrun) ? vrun : maxrun;
      hold_prev = (m_valid === 1'b1) && !rdy && !r;
      prev_data = m_data;
      prev_last = m_last;
      if (!r && m_valid1 === 1'b1) q1.push_back({m_last1, m_data1});
    end
    if (r) begin
      mcnt = 0; mcsum = '0; mpkts = 0; issued = 0; popped = 0; hold_prev = 0;
      if (fl) exp_q.delete();
    end
    rst_prev = r;
    started  = 1;
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b0;
    // Reset held with the FIFO non-empty; the preload becomes the first packet.
    tick(0, 1, 0, 0, 8'h00);
    tick(0, 1, 0, 1, 8'h11);
    tick(0, 1, 0, 1, 8'h22);
    tick(0, 1, 0, 1, 8'h33);
    tick(0, 1, 0, 1, 8'h44);

    for (int i = 0; i < 30 && mpkts < 1; i++) tick(1, 0, 0, 0, 8'h00);
    chk("single_done", mpkts, 1);
    chk("single_csum", last_cs, 8'h44);
    chk("first_latency", first_vld - first_ren, 2);

    vrun = 0; maxrun = 0;
    for (int i = 1; i <= 8; i++) tick(1, 0, 0, 1, 8'(i));
    for (int i = 0; i < 30 && mpkts < 3; i++) tick(1, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 8'h00);
    chk("b2b_done", mpkts, 3);
    chk("b2b_run", maxrun, 10);
    chk("b2b_csum0", cs_log[$-1], 8'h04);
    chk("b2b_csum1", cs_log[$], 8'h0C);

    base = ren_total;
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 8'h81 + 8'(i));
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 8'h00);
    chk("bp_reads", ren_total - base, 3);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'h81);
    for (int i = 0; i < 40 && mpkts < 5; i++) tick(1, 0, 0, 0, 8'h00);
    chk("bp_done", mpkts, 5);
    chk("bp_drained", exp_q.size(), 0);

    tick(1, 0, 0, 1, 8'hA0);
    tick(1, 0, 0, 1, 8'hB0);
    tick(1, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 0, 8'h00);
      chk("gap_valid", m_valid, 0);
    end
    chk("gap_beat", mcnt, 2);
    tick(1, 0, 0, 1, 8'hC0);
    tick(1, 0, 0, 1, 8'hD0);
    for (int i = 0; i < 20 && mpkts < 6; i++) tick(1, 0, 0, 0, 8'h00);
    chk("uf_done", mpkts, 6);
    chk("uf_csum", last_cs, 8'h00);

    for (int i = 0; i < 4; i++) tick(1, 0, 0, 1, 8'h31 + 8'(i));
    chk("mid_beats", mcnt, 2);
    tick(0, 1, 1, 0, 8'h00);
    tick(0, 0, 0, 0, 8'h00);
    chk("mid_pkt_count", pkt_count, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 1, 8'h61 + 8'(i));
    for (int i = 0; i < 20 && mpkts < 1; i++) tick(1, 0, 0, 0, 8'h00);
    chk("mid_done", mpkts, 1);
    chk("mid_csum", last_cs, 8'h04);

    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) != 0, 0, 0, $urandom_range(0, 2) != 0, 8'($urandom));
    pad = (PL - ((mcnt + exp_q.size()) % PL)) % PL;
    for (int i = 0; i < pad; i++) tick(1, 0, 0, 1, 8'($urandom));
    for (int i = 0; i < 400 && (exp_q.size() != 0 || mcnt != 0); i++) tick(1, 0, 0, 0, 8'h00);
    chk("rand_drained", exp_q.size() + mcnt, 0);

    push1 = 1;
    for (int i = 0; i < 8; i++) tick(1, 0, 0, 0, 8'h00);
    chk("p1_beats", q1.size(), 2);
    if (q1.size() == 2) begin
      chk("p1_b0", q1[0], {1'b0, 8'h5A});
      chk("p1_b1", q1[1], {1'b1, 8'h5A});
    end
    chk("p1_count", pkt_count1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
